// File: rtl/interpo_pkg.sv
// Shared width helpers and stage-valid type for the interpo_lerp_pipe datapath.
package interpo_pkg;

  function automatic int sample_w(input int msbi);
    return msbi + 1;
  endfunction

  // One extra bit so that B - A is representable as a signed value.
  function automatic int diff_w(input int msbi);
    return msbi + 2;
  endfunction

  // diff (MSBI+2) times the zero-extended signed weight (WBITS+1).
  function automatic int prod_w(input int msbi, input int wbits);
    return msbi + wbits + 3;
  endfunction

  typedef struct packed {
    logic s2;
    logic s1;
    logic s0;
  } stage_valid_t;

endpackage

// File: rtl/interpo_lerp_ch.sv
// One channel of the 3-stage lerp datapath: capture diff, multiply, add.
// INTERPO_ROUND_EN selects round-half-up instead of floor in the final shift.
module interpo_lerp_ch
  import interpo_pkg::*;
#(
  parameter int MSBI  = 4,
  parameter int WBITS = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                ld0,
  input  logic                ld1,
  input  logic                ld2,
  input  logic [MSBI:0]       a,
  input  logic [MSBI:0]       b,
  input  logic [WBITS-1:0]    w,
  output logic [MSBI:0]       out
);

  localparam int SW = sample_w(MSBI);
  localparam int DW = diff_w(MSBI);
  localparam int PW = prod_w(MSBI, WBITS);

  logic signed [DW-1:0] diff_q;
  logic        [SW-1:0] a0_q;
  logic     [WBITS-1:0] w0_q;
  logic signed [PW-1:0] prod_q;
  logic        [SW-1:0] a1_q;

  logic signed [DW-1:0] diff_c;
  logic signed [PW-1:0] diff_x;
  logic signed [PW-1:0] w_x;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] biased_c;
  logic signed [PW-1:0] shifted_c;
  logic signed [PW-1:0] sum_c;

  always_comb begin
    diff_c    = $signed({1'b0, b}) - $signed({1'b0, a});
    diff_x    = {{(PW-DW){diff_q[DW-1]}}, diff_q};
    w_x       = {{(PW-WBITS){1'b0}}, w0_q};
    prod_c    = diff_x * w_x;
`ifdef INTERPO_ROUND_EN
    biased_c  = prod_q + $signed({{(PW-1){1'b0}}, 1'b1} << (WBITS-1));
`else
    biased_c  = prod_q;
`endif
    shifted_c = biased_c >>> WBITS;
    // Result stays inside [min(A,B), max(A,B)], so the low SW bits are exact.
    sum_c     = $signed({{(PW-SW){1'b0}}, a1_q}) + shifted_c;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      diff_q <= '0;
      a0_q   <= '0;
      w0_q   <= '0;
      prod_q <= '0;
      a1_q   <= '0;
      out    <= '0;
    end else begin
      if (ld0) begin
        diff_q <= diff_c;
        a0_q   <= a;
        w0_q   <= w;
      end
      if (ld1) begin
        prod_q <= prod_c;
        a1_q   <= a0_q;
      end
      if (ld2) begin
        out <= sum_c[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/interpo_lerp_pipe.sv
// Multi-channel pipelined linear interpolation with valid/ready backpressure.
// Optional build macro: INTERPO_ROUND_EN (round-half-up in the final stage).
module interpo_lerp_pipe
  import interpo_pkg::*;
#(
  parameter int MSBI  = 4,
  parameter int WBITS = 3,
  parameter int NCH   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NCH*(MSBI+1)-1:0] in_a,
  input  logic [NCH*(MSBI+1)-1:0] in_b,
  input  logic [WBITS-1:0]        in_weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*(MSBI+1)-1:0] out_data
);

  localparam int SW = sample_w(MSBI);

  stage_valid_t v_q;
  logic en0, en1, en2;
  logic ld0, ld1, ld2;

  // Handshake: a beat moves on the clock edge where valid & ready are both 1.
  // Stage k may load when it is empty or stage k+1 is taking its beat this cycle.
  always_comb begin
    en2 = ~v_q.s2 | out_ready;
    en1 = ~v_q.s1 | en2;
    en0 = ~v_q.s0 | en1;
    ld0 = en0 & in_valid;
    ld1 = en1 & v_q.s0;
    ld2 = en2 & v_q.s1;
  end

  assign in_ready  = en0;
  assign out_valid = v_q.s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q <= '0;
    end else begin
      if (en0) v_q.s0 <= in_valid;
      if (en1) v_q.s1 <= v_q.s0;
      if (en2) v_q.s2 <= v_q.s1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    interpo_lerp_ch #(
      .MSBI  (MSBI),
      .WBITS (WBITS)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .ld0     (ld0),
      .ld1     (ld1),
      .ld2     (ld2),
      .a       (in_a[c*SW +: SW]),
      .b       (in_b[c*SW +: SW]),
      .w       (in_weight),
      .out     (out_data[c*SW +: SW])
    );
  end

endmodule

// File: tb/tb_interpo_lerp_pipe.sv
// Self-checking bench for interpo_lerp_pipe (MSBI=4, WBITS=3, NCH=3).
module tb_interpo_lerp_pipe;

  localparam int MSBI = 4;
  localparam int WB   = 3;
  localparam int NCH  = 3;
  localparam int SW   = MSBI + 1;
  localparam int DW   = NCH * SW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_a = '0;
  logic [DW-1:0] in_b = '0;
  logic [WB-1:0] in_weight = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic stall_mon = 1'b0;
  logic saw_in_ready_low = 1'b0;
  int stale_seen = 0;

  interpo_lerp_pipe #(.MSBI(MSBI), .WBITS(WB), .NCH(NCH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] lerp_model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                              input logic [WB-1:0] w);
    logic [DW-1:0] r;
    logic [SW-1:0] sa, sb;
    int d, p, s;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      sa = a[c*SW +: SW];
      sb = b[c*SW +: SW];
      d  = int'(sb) - int'(sa);
      p  = d * int'(w);
`ifdef INTERPO_ROUND_EN
      p  = p + (1 << (WB - 1));
`endif
      s  = p >>> WB;
      r[c*SW +: SW] = SW'(int'(sa) + s);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rep3(input logic [SW-1:0] v);
    return {v, v, v};
  endfunction

  // Driver: present a beat, wait for acceptance, push the expected result.
  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [WB-1:0] w);
    int waited;
    in_a = a; in_b = b; in_weight = w; in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(lerp_model(a, b, w));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      waited++;
      if (waited > 50) begin
        check_val("accept_timeout", 64'(waited), 64'(0));
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_random();
    send_beat(DW'($urandom), DW'($urandom), WB'($urandom_range(0, 7)));
  endtask

  // Called right after send_beat returns, i.e. 1 time unit past the accept edge.
  task automatic check_latency(input string tag);
    int cnt;
    cnt = 1;
    while (!out_valid && cnt < 12) begin
      @(posedge clk); #1;
      cnt++;
    end
    check_val(tag, 64'(cnt), 64'(3));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check_val(tag, 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard: compare on the negedge before each output handshake edge.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          stale_seen++;
          check_val("unexpected_beat", 64'(out_data), 64'(0));
        end else begin
          check_val("out_data", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end else if (stall_mon && exp_q.size() != 0) begin
        check_val("stall_hold", 64'(out_data), 64'(exp_q[0]));
        if (!in_ready) saw_in_ready_low = 1'b1;
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check_val("rst_out_valid", 64'(out_valid), 64'(0));
    check_val("rst_out_data", 64'(out_data), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check_val("idle_in_ready", 64'(in_ready), 64'(1));

    // Directed points, each with a latency measurement on an empty pipe
    send_beat(rep3(5'd8), rep3(5'd24), 3'd4);   check_latency("lat_8_24_4");   drain("drain_a");
    send_beat(rep3(5'd24), rep3(5'd8), 3'd3);   check_latency("lat_24_8_3");   drain("drain_b");
    send_beat(rep3(5'd5), rep3(5'd0), 3'd3);    check_latency("lat_5_0_3");    drain("drain_c");
    send_beat(rep3(5'd0), rep3(5'd5), 3'd3);    check_latency("lat_0_5_3");    drain("drain_d");
    send_beat({5'd17, 5'd31, 5'd0}, {5'd17, 5'd0, 5'd31}, 3'd7);
    drain("drain_ch");
    for (int i = 0; i < 4; i++) send_beat(DW'($urandom), DW'($urandom), 3'd0);
    drain("drain_w0");
    // Extreme weight and full-range endpoints
    send_beat(rep3(5'd0), rep3(5'd31), 3'd7);
    send_beat(rep3(5'd31), rep3(5'd0), 3'd7);
    send_beat(rep3(5'd31), rep3(5'd31), 3'd5);
    drain("drain_edges");

    // Back-to-back stream of 10 with a 5-clock output stall
    stall_mon = 1'b1;
    fork
      begin
        for (int i = 0; i < 10; i++) send_random();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stream");
    stall_mon = 1'b0;
    check_val("in_ready_fell", 64'(saw_in_ready_low), 64'(1));

    // Random traffic with random backpressure
    fork
      begin
        for (int i = 0; i < 30; i++) send_random();
      end
      begin
        repeat (60) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("drain_rand");

    // Reset with two beats in flight
    out_ready = 1'b0;
    send_random();
    send_random();
    repeat (2) @(posedge clk);
    #3;
    check_val("pre_reset_valid", 64'(out_valid), 64'(1));
    reset_n = 1'b0;
    #1;
    check_val("async_reset_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    stale_seen = 0;
    repeat (6) @(posedge clk);
    #1;
    check_val("no_stale_beat", 64'(stale_seen), 64'(0));
    send_beat(rep3(5'd8), rep3(5'd24), 3'd4);
    check_latency("lat_after_reset");
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
